// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with push/pop strobes, replace-top, count and sticky error flags
// Optional: LIFO_STACK_WRAP_EN makes push-while-full overwrite the oldest entry.
module lifo_stack #(
  parameter int width = 8,
  parameter int depth = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] push_data,
  input  logic             err_clr,
  output logic [width-1:0] peek,
  output logic [depth:0]   count,
  output logic             full,
  output logic             not_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [width-1:0] mem [2**depth];

  logic [depth-1:0] tp_q, tp_d;
  logic [depth:0]   count_q, count_d;
  logic [width-1:0] peek_q, peek_d;
  logic             full_q, not_empty_q, ovf_q, unf_q;
  logic             ovf_d, unf_d, ovf_set, unf_set;
  logic             wr_en;
  logic [depth-1:0] wr_addr;
  logic [depth-1:0] tp_p1, tp_m1;
  logic             is_full, is_empty;

  assign tp_p1    = tp_q + depth'(1);
  assign tp_m1    = tp_q - depth'(1);
  // count never exceeds 2**depth, so its MSB alone marks full
  assign is_full  = count_q[depth];
  assign is_empty = (count_q == '0);

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    peek_d  = peek_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    wr_en   = 1'b0;
    wr_addr = tp_p1;
    if (en) begin
      if (push && pop) begin
        if (is_empty) begin
          wr_en   = 1'b1;
          tp_d    = tp_p1;
          count_d = count_q + (depth+1)'(1);
          peek_d  = push_data;
          unf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = tp_q;
          peek_d  = push_data;
        end
      end else if (push) begin
        if (!is_full) begin
          wr_en   = 1'b1;
          tp_d    = tp_p1;
          count_d = count_q + (depth+1)'(1);
          peek_d  = push_data;
        end else begin
          ovf_set = 1'b1;
`ifdef LIFO_STACK_WRAP_EN
          wr_en   = 1'b1;
          tp_d    = tp_p1;
          peek_d  = push_data;
`endif
        end
      end else if (pop) begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          tp_d    = tp_m1;
          count_d = count_q - (depth+1)'(1);
          peek_d  = (count_q > (depth+1)'(1)) ? mem[tp_m1] : '0;
        end
      end
    end
    // a same-cycle error wins over err_clr
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    unf_d = unf_set | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tp_q        <= '0;
      count_q     <= '0;
      peek_q      <= '0;
      full_q      <= 1'b0;
      not_empty_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      count_q     <= count_d;
      peek_q      <= peek_d;
      full_q      <= count_d[depth];
      not_empty_q <= (count_d != '0);
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && wr_en) mem[wr_addr] <= push_data;
  end

  assign peek      = peek_q;
  assign count     = count_q;
  assign full      = full_q;
  assign not_empty = not_empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - scoreboard bench for lifo_stack (depth=2, width=8)
module tb_lifo_stack;

  logic       clk = 1'b0;
  logic       clr, en, push, pop, err_clr;
  logic [7:0] push_data;
  logic [7:0] peek;
  logic [2:0] count;
  logic       full, not_empty, overflow, underflow;

  always #5 clk = ~clk;

  lifo_stack #(.width(8), .depth(2)) dut (
    .clk(clk), .clr(clr), .en(en), .push(push), .pop(pop),
    .push_data(push_data), .err_clr(err_clr),
    .peek(peek), .count(count), .full(full), .not_empty(not_empty),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct packed {
    logic [7:0] peek;
    logic [2:0] count;
    logic       full;
    logic       ne;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] stk[$];
  logic       m_ovf, m_unf;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict with a queue-based stack, compare after the edge.
  task automatic cyc(input logic c, input logic e, input logic pu, input logic po,
                     input logic [7:0] d, input logic ec);
    exp_t x;
    logic os, us;
    clr = c; en = e; push = pu; pop = po; push_data = d; err_clr = ec;
    os = 1'b0; us = 1'b0;
    if (c) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (e) begin
        if (pu && po) begin
          if (stk.size() == 0) begin stk.push_back(d); us = 1'b1; end
          else stk[stk.size()-1] = d;
        end else if (pu) begin
          if (stk.size() < 4) stk.push_back(d);
          else begin
            os = 1'b1;
`ifdef LIFO_STACK_WRAP_EN
            stk.delete(0);
            stk.push_back(d);
`endif
          end
        end else if (po) begin
          if (stk.size() == 0) us = 1'b1;
          else void'(stk.pop_back());
        end
      end
      m_ovf = os | (m_ovf & ~ec);
      m_unf = us | (m_unf & ~ec);
    end
    x.peek  = (stk.size() != 0) ? stk[stk.size()-1] : 8'h00;
    x.count = 3'(stk.size());
    x.full  = (stk.size() == 4);
    x.ne    = (stk.size() != 0);
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("peek", 32'(peek), 32'(x.peek));
    check("count", 32'(count), 32'(x.count));
    check("full", 32'(full), 32'(x.full));
    check("not_empty", 32'(not_empty), 32'(x.ne));
    check("overflow", 32'(overflow), 32'(x.ovf));
    check("underflow", 32'(underflow), 32'(x.unf));
  endtask

  task automatic do_push(input logic [7:0] d); cyc(0, 1, 1, 0, d, 0); endtask
  task automatic do_pop();                     cyc(0, 1, 0, 1, 8'h00, 0); endtask

  initial begin
    logic [7:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    m_ovf = 1'b0; m_unf = 1'b0;

    cyc(1, 0, 0, 0, 8'h00, 0);
    check("rst_count", 32'(count), 32'd0);

    foreach (fill[i]) do_push(fill[i]);
    check("fill_peek", 32'(peek), 32'h44);
    check("fill_full", 32'(full), 32'd1);
    repeat (4) do_pop();
    check("drain_ne", 32'(not_empty), 32'd0);

    do_pop();
    cyc(0, 1, 0, 0, 8'h00, 0);
    check("unf_sticky", 32'(underflow), 32'd1);
    cyc(0, 1, 0, 0, 8'h00, 1);
    check("unf_clr", 32'(underflow), 32'd0);
    do_pop();
    cyc(0, 1, 0, 1, 8'h00, 1);
    check("unf_setwins", 32'(underflow), 32'd1);
    cyc(0, 0, 0, 0, 8'h00, 1);

    do_push(8'hA1);
    do_push(8'hA2);
    cyc(0, 1, 1, 1, 8'hB7, 0);
    check("rt_peek", 32'(peek), 32'hB7);
    do_pop();
    check("rt_pop", 32'(peek), 32'hA1);
    do_pop();
    cyc(0, 1, 1, 1, 8'hC3, 0);
    check("rt_empty_unf", 32'(underflow), 32'd1);

    cyc(1, 1, 0, 0, 8'h00, 0);
    foreach (fill[i]) do_push(fill[i]);
    do_push(8'h55);
`ifdef LIFO_STACK_WRAP_EN
    check("ovf_peek", 32'(peek), 32'h55);
`else
    check("ovf_peek", 32'(peek), 32'h44);
`endif
    check("ovf_flag", 32'(overflow), 32'd1);
    repeat (4) do_pop();

    cyc(1, 1, 0, 0, 8'h00, 0);
    foreach (fill[i]) do_push(fill[i]);
    cyc(0, 1, 1, 1, 8'h66, 0);
    check("rt_full_ovf", 32'(overflow), 32'd0);
    cyc(0, 0, 1, 0, 8'h99, 0);
    cyc(0, 0, 0, 1, 8'h99, 0);
    check("en0_peek", 32'(peek), 32'h66);

    cyc(1, 1, 0, 0, 8'h00, 0);
    do_push(8'h01);
    do_push(8'h02);
    cyc(1, 1, 1, 0, 8'h03, 0);
    check("clr_burst", 32'(count), 32'd0);
    do_push(8'h04);

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) != 0),
          1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
